uart_rx_fifo_pb: RTL
====================

# uart_rx_fifo_pb

Serial receiver for the PicoBlaze UART echo design. It takes the asynchronous RX line, recovers 8N1 bytes using 16x oversampling, and buffers them in a first-word-fall-through FIFO. The PicoBlaze drains the FIFO through its input-port read strobe. It is the receive side of the link that the testbench 16550 model drives via `RX`.

## Interface
- BAUD_DIV, 54, CLK_IN cycles per 16x sample tick (100 MHz / (16 × 115200) ≈ 54)
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16

- CLK_IN  in  1  system clock, 100 MHz
- RESET_IN  in  1  asynchronous, active-high reset
- RX  in  1  serial input, idle high, asynchronous to CLK_IN
- rd_strobe  in  1  PicoBlaze read strobe; pops FIFO head when data_present=1
- data_out  out  8  FIFO head byte; valid while data_present=1
- data_present  out  1  FIFO non-empty
- half_full  out  1  FIFO count ≥ 2**(FIFO_AW-1)
- fifo_full  out  1  FIFO count = 2**FIFO_AW
- framing_error  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte completed while FIFO full, byte dropped

## Operation
- RX passes through a 2-flop synchronizer, both flops reset to 1. All logic uses the synced value `rxs`.
- Tick generator: counter runs 0..BAUD_DIV-1 and pulses `tick` when count = BAUD_DIV-1, then wraps to 0. The counter is free-running and resets to 0.
- A 4-bit sample counter `sc` advances on each tick. A 3-bit `bitn` counts data bits. An 8-bit shift register receives data LSB first.
- FSM states are IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE.
  - IDLE: when rxs=0, clear sc and enter START.
  - START: on the tick where sc=7 (mid start bit), sample rxs. If it is 1, treat it as a glitch and return to IDLE with no output. If it is 0, clear sc and bitn and enter DATA.
  - DATA: on the tick where sc=15, shift in rxs at bit 7 (shift right). Once bitn=7 has been sampled, enter STOP; otherwise increment bitn.
  - STOP: on the tick where sc=15, sample rxs.
    - rxs=1 and FIFO not full: write the byte, go to IDLE.
    - rxs=1 and FIFO full: pulse overrun, drop the byte, go to IDLE.
    - rxs=0: pulse framing_error, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay here until rxs=1 (break/line-low handling), then go to IDLE.
- FIFO: 2**FIFO_AW × 8 storage, write and read pointers of FIFO_AW bits that wrap modulo depth, and a count of FIFO_AW+1 bits.
  - data_out = mem[rd_ptr] (fall-through).
  - Pop occurs on rd_strobe=1 with count>0. rd_strobe on an empty FIFO is ignored, with no pointer change.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - When the FIFO is full and a pop occurs in the same cycle as the STOP-state write, the write is accepted and no overrun is reported. The full check uses the count after the pop.
- Reset values: data_out=0x00 (storage cleared or data_out gated), data_present=0, half_full=0, fifo_full=0, framing_error=0, overrun=0, pointers/count=0, FSM=IDLE.
- Reset mid-frame abandons the partial byte. After release, a frame whose start bit was missed is resynchronised only on the next falling edge seen from IDLE.

## Timing
- Synchronizer latency: 2 cycles from RX edge to rxs.
- Start-edge detection to FIFO write: 8 + 16×9 = 152 ticks (±1 tick of phase), i.e. ≤ 152×BAUD_DIV + BAUD_DIV + 3 cycles from the RX falling edge.
- FIFO write at clock edge N: data_present, count flags, and data_out (if the FIFO was empty) update at edge N (registered, visible in cycle N+1).
- Pop at edge N: data_out shows the next entry in cycle N+1. PicoBlaze samples data_out in the same cycle it asserts rd_strobe.
- framing_error and overrun are high for exactly one CLK_IN cycle, registered at the STOP decision edge.
- Back-to-back frames: the stop bit ends at sc=15 mid-bit, so IDLE is re-entered half a bit early. This tolerates ≥ +3% baud mismatch.

## Test plan
- UART model at 115200 sends 0x31 → data_present rises after ~82.5 µs with data_out=0x31; one rd_strobe pulse → data_present=0 the next cycle.
- Send 0x00..0x0F back-to-back with no reads → half_full asserts at 8 entries and fifo_full at 16. A 17th byte 0xAA → overrun pulses once. Sixteen reads return 0x00..0x0F in order; 0xAA never appears.
- Drive RX low for 3 µs (≈ 1/3 bit) then high → no write, no error pulse, FSM back in IDLE.
- Send 0x55 with the stop bit forced low and RX held low for 2 bit times → framing_error pulses once, no write. The next valid 0x33 is received correctly.
- With the FIFO full, assert rd_strobe in the exact cycle of the STOP write of 0x77 → no overrun, count stays 16, and 0x77 is the last entry read.
- Assert RESET_IN for 10 cycles during data bit 4 of 0x5A, then send 0xA5 → only 0xA5 lands in the FIFO. All outputs read their reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo_pb.sv
// rtl/uart_rx_fifo_pb.sv - 8N1 UART receiver with 16x oversampling and FWFT receive FIFO
//
// Purpose: recovers 8N1 bytes from the asynchronous RX line and buffers them in a
// first-word-fall-through FIFO that the PicoBlaze drains with its read strobe.
//
// Ports:
//   CLK_IN        in   system clock
//   RESET_IN      in   asynchronous, active-high reset
//   RX            in   serial input, idle high, asynchronous to CLK_IN
//   rd_strobe     in   pops the FIFO head when data_present=1
//   data_out      out  FIFO head byte, 0x00 while the FIFO is empty
//   data_present  out  FIFO non-empty
//   half_full     out  FIFO count >= depth/2
//   fifo_full     out  FIFO count = depth
//   framing_error out  one-cycle pulse: stop bit sampled low
//   overrun       out  one-cycle pulse: completed byte dropped because FIFO full

module uart_rx_fifo_pb #(
  parameter int BAUD_DIV = 54,
  parameter int FIFO_AW  = 4
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       RX,
  input  logic       rd_strobe,
  output logic [7:0] data_out,
  output logic       data_present,
  output logic       half_full,
  output logic       fifo_full,
  output logic       framing_error,
  output logic       overrun
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] HALF_CNT = (FIFO_AW + 1)'(DEPTH / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic              rx_meta;
  logic              rxs;
  logic [BW-1:0]     baud_cnt;
  logic              tick;
  state_t            state;
  logic [3:0]        sc;
  logic [2:0]        bitn;
  logic [7:0]        shreg;

  logic [7:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]  count;

  logic              pop;
  logic              room;
  logic              stop_sample;
  logic              push;

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  // Free-running 16x oversampling tick.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == BAUD_LAST);

  assign pop         = rd_strobe && (count != '0);
  // A pop in the same cycle frees a slot, so the full test looks past it.
  assign room        = (count != FULL_CNT) || pop;
  assign stop_sample = (state == STOP) && tick && (sc == 4'd15);
  assign push        = stop_sample && rxs && room;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state         <= IDLE;
      sc            <= 4'd0;
      bitn          <= 3'd0;
      shreg         <= 8'h00;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            sc    <= 4'd0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (sc == 4'd7) begin
              // Mid start bit: a high line here means the edge was a glitch.
              if (rxs) begin
                state <= IDLE;
              end else begin
                sc    <= 4'd0;
                bitn  <= 3'd0;
                state <= DATA;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == 4'd15) begin
              shreg <= {rxs, shreg[7:1]};
              if (bitn == 3'd7) begin
                state <= STOP;
              end else begin
                bitn <= bitn + 3'd1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == 4'd15) begin
              if (!rxs) begin
                framing_error <= 1'b1;
                state         <= WAIT_IDLE;
              end else begin
                overrun <= !room;
                state   <= IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is not
          // re-read as a stream of 0x00 frames.
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; data_out is gated while empty instead.
  always_ff @(posedge CLK_IN) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_present = (count != '0);
  assign half_full    = (count >= HALF_CNT);
  assign fifo_full    = (count == FULL_CNT);
  assign data_out     = data_present ? mem[rd_ptr] : 8'h00;

endmodule
